// File: rtl/source_stream_adapter.sv
// Credit-limited request adapter from a one-cycle-latency word source to a valid/ready stream.
// Optional macro STREAM_ADAPTER_COUNT_EN adds the word_count handshake counter port.
module source_stream_adapter #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  src_ready,
  input  logic                  src_valid,
  input  logic                  src_empty,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  done,
  output logic                  overflow
`ifdef STREAM_ADAPTER_COUNT_EN
  ,
  output logic [31:0]           word_count
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned NENT = DEPTH;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW:0]   CREDIT   = (CW + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  inflight;
  logic                  push;
  logic                  pop;
  logic                  drop;

  // Credit covers buffered words plus the one possibly on its way back;
  // a same-cycle pop is deliberately not counted as freeing space.
  always_comb begin
    src_ready = ~reset & ~src_empty & ~done &
                (({1'b0, count} + {{CW{1'b0}}, inflight}) < CREDIT);
    out_valid = (count != '0);
    out_data  = mem[rd_ptr];
    pop       = out_valid & out_ready;
    push      = src_valid & ((count != FULL_CNT) | pop);
    drop      = src_valid & (count == FULL_CNT) & ~pop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < NENT; i++) begin
        mem[i] <= '0;
      end
`ifdef STREAM_ADAPTER_COUNT_EN
      word_count <= '0;
`endif
    end else begin
      inflight <= src_ready;
      if (push) begin
        mem[wr_ptr] <= src_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      if (src_empty && !inflight && !src_valid && (count == '0)) begin
        done <= 1'b1;
      end
`ifdef STREAM_ADAPTER_COUNT_EN
      if (pop) begin
        word_count <= word_count + 32'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_source_stream_adapter.sv
// Self-checking bench for source_stream_adapter: emulated file source, queue-based reference model,
// per-cycle comparison plus directed literal checks and a randomized run.
module tb_source_stream_adapter;

  logic        clk;
  logic        reset;
  logic        src_ready;
  logic        src_valid;
  logic        src_empty;
  logic [31:0] src_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        done;
  logic        overflow;
`ifdef STREAM_ADAPTER_COUNT_EN
  logic [31:0] word_count;
`endif

  source_stream_adapter #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .src_ready (src_ready),
    .src_valid (src_valid),
    .src_empty (src_empty),
    .src_data  (src_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .done      (done),
    .overflow  (overflow)
`ifdef STREAM_ADAPTER_COUNT_EN
    ,
    .word_count(word_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_en = 0;
  logic        req = 1'b0;
  logic [31:0] src_q[$];
  logic [31:0] rec[$];
  bit          rec_en = 0;
  bit          force_v = 0;
  logic [31:0] force_d = '0;

  // Reference model: FIFO contents as a queue, plus the sticky flags.
  logic [31:0] m_q[$];
  bit          m_infl = 0;
  bit          m_done = 0;
  bit          m_ovf = 0;
  logic [31:0] m_wc = '0;
  int          m_sz;
  bit          m_rdy;
  bit          m_pop;
  bit          e_rdy;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_infl = 0;
      m_done = 0;
      m_ovf  = 0;
      m_wc   = '0;
    end else begin
      m_sz  = m_q.size();
      m_rdy = !src_empty && !m_done && (m_sz + int'(m_infl) < 4);
      m_pop = (m_sz != 0) && out_ready;
      if (src_empty && !m_infl && !src_valid && m_sz == 0) m_done = 1;
      if (m_pop) begin
        void'(m_q.pop_front());
        m_wc = m_wc + 1;
      end
      if (src_valid) begin
        if (m_sz < 4 || m_pop) m_q.push_back(src_data);
        else m_ovf = 1;
      end
      m_infl = m_rdy;
    end
  end

  always @(negedge clk) begin
    req = src_ready;
    if (chk_en) begin
      e_rdy = !reset && !src_empty && !m_done && (m_q.size() + int'(m_infl) < 4);
      chk("src_ready", 64'(src_ready), 64'(e_rdy));
      chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
      if (m_q.size() != 0) chk("out_data", 64'(out_data), 64'(m_q[0]));
      chk("done", 64'(done), 64'(m_done));
      chk("overflow", 64'(overflow), 64'(m_ovf));
`ifdef STREAM_ADAPTER_COUNT_EN
      chk("word_count", 64'(word_count), 64'(m_wc));
`endif
    end
  end

  // Source emulation: a request seen high at an edge yields a word just after it.
  task automatic tick();
    if (rec_en && !reset && out_valid && out_ready) rec.push_back(out_data);
    @(posedge clk);
    #1;
    if (req && src_q.size() != 0) begin
      src_valid = 1'b1;
      src_data  = src_q.pop_front();
    end else begin
      src_valid = 1'b0;
    end
    if (force_v) begin
      src_valid = 1'b1;
      src_data  = force_d;
      force_v   = 0;
    end
    src_empty = (src_q.size() == 0);
    #1;
  endtask

  task automatic run_reset();
    reset = 1'b1;
    tick();
    tick();
  endtask

  task automatic load_seq(input logic [31:0] base, input int n);
    src_q.delete();
    for (int i = 0; i < n; i++) src_q.push_back(base + 32'(i));
    src_empty = (src_q.size() == 0);
    rec.delete();
  endtask

  task automatic check_seq(input string nm, input logic [31:0] exp[$]);
    chk({nm, "_len"}, 64'(rec.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < rec.size(); i++) chk(nm, 64'(rec[i]), 64'(exp[i]));
  endtask

  logic [31:0] expl[$];
  int          first_req;
  int          first_val;
  int          last_val;
  int          done_t;

  initial begin
    reset     = 1'b1;
    src_valid = 1'b0;
    src_data  = '0;
    src_empty = 1'b0;
    out_ready = 1'b0;
    tick();
    chk_en = 1;
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_src_ready", 64'(src_ready), 64'd0);

    // Free-flowing 8-word stream
    load_seq(32'h01, 8);
    out_ready = 1'b1;
    rec_en    = 1;
    reset     = 1'b0;
    first_req = -1; first_val = -1; last_val = -1; done_t = -1;
    #1;
    if (src_ready) first_req = 0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (first_req < 0 && src_ready) first_req = t;
      if (out_valid) begin
        if (first_val < 0) first_val = t;
        last_val = t;
      end
      if (done_t < 0 && done) done_t = t;
    end
    chk("t1_first_req", 64'(first_req), 64'd0);
    chk("t1_latency", 64'(first_val - first_req), 64'd2);
    chk("t1_done_after_pop", 64'(done_t - last_val), 64'd2);
    chk("t1_done_cycle", 64'(done_t), 64'd11);
    expl.delete();
    for (int i = 1; i <= 8; i++) expl.push_back(32'(i));
    check_seq("t1_seq", expl);
    chk("t1_overflow", 64'(overflow), 64'd0);
`ifdef STREAM_ADAPTER_COUNT_EN
    chk("t1_word_count", 64'(word_count), 64'd8);
`endif

    // Downstream stalled until cycle 20
    run_reset();
    load_seq(32'h01, 8);
    out_ready = 1'b0;
    reset     = 1'b0;
    for (int t = 1; t <= 45; t++) begin
      tick();
      if (t == 10) begin
        chk("t2_src_ready_held", 64'(src_ready), 64'd0);
        chk("t2_head_valid", 64'(out_valid), 64'd1);
        chk("t2_head_data", 64'(out_data), 64'h01);
        chk("t2_overflow", 64'(overflow), 64'd0);
      end
      if (t == 19) out_ready = 1'b1;
    end
    check_seq("t2_seq", expl);
    chk("t2_done", 64'(done), 64'd1);

    // Source empty from reset
    run_reset();
    load_seq(32'h0, 0);
    reset = 1'b0;
    #1;
    chk("t3_ready_release", 64'(src_ready), 64'd0);
    chk("t3_done_release", 64'(done), 64'd0);
    tick();
    chk("t3_done_first_edge", 64'(done), 64'd1);
    chk("t3_out_valid", 64'(out_valid), 64'd0);

    // Full FIFO with simultaneous pop and forced arrival: accepted
    run_reset();
    load_seq(32'h11, 6);
    out_ready = 1'b0;
    reset     = 1'b0;
    for (int t = 0; t < 8; t++) tick();
    chk("t4_full_valid", 64'(out_valid), 64'd1);
    chk("t4_full_ready", 64'(src_ready), 64'd0);
    force_d = 32'hAA;
    force_v = 1;
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    chk("t4_still_full", 64'(src_ready), 64'd0);
    chk("t4_no_overflow", 64'(overflow), 64'd0);
    chk("t4_next_head", 64'(out_data), 64'h12);
    out_ready = 1'b1;
    for (int t = 0; t < 20; t++) tick();
    expl.delete();
    expl.push_back(32'h11); expl.push_back(32'h12); expl.push_back(32'h13);
    expl.push_back(32'h14); expl.push_back(32'hAA); expl.push_back(32'h15);
    expl.push_back(32'h16);
    check_seq("t4_seq", expl);
    chk("t4_done", 64'(done), 64'd1);

    // Full FIFO, no pop, forced arrival: dropped and sticky overflow
    run_reset();
    load_seq(32'h21, 6);
    out_ready = 1'b0;
    reset     = 1'b0;
    for (int t = 0; t < 8; t++) tick();
    force_d = 32'hBB;
    force_v = 1;
    tick();
    tick();
    chk("t5_overflow", 64'(overflow), 64'd1);
    chk("t5_head", 64'(out_data), 64'h21);
    for (int t = 0; t < 3; t++) tick();
    chk("t5_overflow_sticky", 64'(overflow), 64'd1);
    chk("t5_ready", 64'(src_ready), 64'd0);
    run_reset();
    chk("t5_rst_overflow", 64'(overflow), 64'd0);
    chk("t5_rst_valid", 64'(out_valid), 64'd0);

    // Reset mid-stream with 3 buffered and one in flight
    load_seq(32'h41, 10);
    out_ready = 1'b0;
    reset     = 1'b0;
    for (int t = 0; t < 4; t++) tick();
    chk("t6_head", 64'(out_data), 64'h41);
    chk("t6_word_arriving", 64'(src_valid), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("t6_valid_cleared", 64'(out_valid), 64'd0);
    chk("t6_done_cleared", 64'(done), 64'd0);
    out_ready = 1'b1;
    for (int t = 0; t < 30; t++) tick();
    expl.delete();
    for (int i = 4; i < 10; i++) expl.push_back(32'h41 + 32'(i));
    check_seq("t6_seq", expl);
    chk("t6_done", 64'(done), 64'd1);

    // Randomized words and downstream back-pressure
    run_reset();
    src_q.delete();
    expl.delete();
    for (int i = 0; i < 40; i++) begin
      expl.push_back($urandom);
      src_q.push_back(expl[i]);
    end
    src_empty = 1'b0;
    rec.delete();
    reset = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    chk("t7_done", 64'(done), 64'd1);
    check_seq("t7_seq", expl);
    chk("t7_overflow", 64'(overflow), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
